// File: rtl/tr_stepper.sv
`default_nettype none
// ============================================================================
// Module  : tr_stepper
// Purpose : Tracking stepper controller. Maps the ADC error to a step period
//           and generates the drv_step train for the motor driver.
//           Define TR_HALF_DUTY_EN for a ~50% duty step output.
// Rev     : 1.0  initial release
// ============================================================================
module tr_stepper #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned L_SHIFT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic        tr_mode_enable,
  input  logic [35:0] x,
  input  logic [31:0] x0,
  input  logic [31:0] dx1,
  input  logic [31:0] dx2,
  input  logic [31:0] k,
  input  logic [31:0] F1,
  input  logic [31:0] F2,
  output logic        drv_step,
  output logic        drv_dir,
  output logic        drv_enable_SM,
  output logic [16:0] N
);

  localparam logic [31:0] c_CLK      = 32'(CLK_HZ);
  localparam logic [16:0] c_QMAX     = 17'h1FFFF;
  localparam logic [16:0] c_QMIN     = 17'd2;
  localparam logic [4:0]  c_DIV_LAST = 5'd17;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_DIV    = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [35:0] r_x;
  logic [31:0] r_f;
  logic        r_dir;
  logic        r_dead;
  logic [31:0] r_rem;
  logic [49:0] r_den;
  logic [17:0] r_q;
  logic [4:0]  r_div_cnt;

  logic        r_run;
  logic [16:0] r_cnt;
  logic [16:0] r_nlat;

  logic        w_ge;
  logic        w_dead;
  logic        w_sat;
  logic [35:0] w_dx;
  logic [31:0] w_ramp;
  logic [63:0] w_prod;
  logic [64:0] w_sum;
  logic [31:0] w_f;
  logic        w_sub;
  logic        w_ovf;
  logic [16:0] w_q;
  logic        w_en_next;
  logic        w_load;
  logic        w_wrap;
  logic        w_run_next;
  logic [16:0] w_cnt_next;
  logic [16:0] w_nlat_next;
  logic        w_step_next;

  // Error -> frequency. In the ramp region dx < dx2 < 2^32, so the low
  // 32 bits of (dx - dx1) are exact and the product fits in 64 bits.
  always_comb begin
    w_ge   = (r_x >= {4'd0, x0});
    w_dx   = w_ge ? (r_x - {4'd0, x0}) : ({4'd0, x0} - r_x);
    w_dead = (w_dx < {4'd0, dx1});
    w_ramp = w_dx[31:0] - dx1;
    w_prod = 64'(w_ramp) * 64'(k);
    w_sum  = {33'd0, F1} + {1'b0, (w_prod >> L_SHIFT)};
    w_sat  = (w_dx >= {4'd0, dx2}) || (w_sum > {33'd0, F2});
    w_f    = w_sat ? F2 : w_sum[31:0];
  end

  // Restoring divider covers quotient bits 17..0; a true quotient beyond
  // that range leaves a remainder >= f, which is treated as saturation.
  always_comb begin
    w_sub = ({18'd0, r_rem} >= r_den);
    w_ovf = r_q[17] || (r_rem >= r_f);
    if (w_ovf) begin
      w_q = c_QMAX;
    end else if (r_q[16:0] < c_QMIN) begin
      w_q = c_QMIN;
    end else begin
      w_q = r_q[16:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_en_next    = drv_enable_SM;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_valid) begin
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        w_state_next = w_dead ? S_UPDATE : S_DIV;
      end
      S_DIV: begin
        if (r_div_cnt == c_DIV_LAST) begin
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_state_next = S_IDLE;
        w_en_next    = !r_dead;
        w_load       = !r_dead;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (!tr_mode_enable) begin
      w_state_next = S_IDLE;
      w_en_next    = 1'b0;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x           <= '0;
      r_f           <= '0;
      r_dir         <= 1'b0;
      r_dead        <= 1'b0;
      r_rem         <= '0;
      r_den         <= '0;
      r_q           <= '0;
      r_div_cnt     <= '0;
      N             <= '0;
      drv_dir       <= 1'b0;
      drv_enable_SM <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_valid && tr_mode_enable) begin
            r_x <= x;
          end
        end
        S_CALC: begin
          r_dir     <= w_ge;
          r_dead    <= w_dead;
          r_f       <= w_f;
          r_rem     <= c_CLK;
          r_den     <= {18'd0, w_f} << 17;
          r_q       <= '0;
          r_div_cnt <= '0;
        end
        S_DIV: begin
          if (w_sub) begin
            r_rem <= r_rem - r_den[31:0];
          end
          r_q       <= {r_q[16:0], w_sub};
          r_den     <= r_den >> 1;
          r_div_cnt <= r_div_cnt + 5'd1;
        end
        default: begin
        end
      endcase
      drv_enable_SM <= w_en_next;
      if (w_load) begin
        N       <= w_q;
        drv_dir <= r_dir;
      end
    end
  end

  // Pulse generator. It follows the next-enable value so that dropping the
  // enable silences drv_step on the same edge; the first enabled cycle
  // after the enable register rises starts a fresh period.
  always_comb begin
    w_wrap      = (r_cnt >= (r_nlat - 17'd1));
    w_run_next  = 1'b0;
    w_cnt_next  = '0;
    w_nlat_next = r_nlat;
    if (w_en_next && drv_enable_SM) begin
      w_run_next = 1'b1;
      if (!r_run || w_wrap) begin
        w_cnt_next  = '0;
        w_nlat_next = N;
      end else begin
        w_cnt_next = r_cnt + 17'd1;
      end
    end
`ifdef TR_HALF_DUTY_EN
    w_step_next = w_run_next && (w_cnt_next < (w_nlat_next >> 1));
`else
    w_step_next = w_run_next && (w_cnt_next == 17'd0);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_nlat   <= '0;
      drv_step <= 1'b0;
    end else begin
      r_run    <= w_run_next;
      r_cnt    <= w_cnt_next;
      r_nlat   <= w_nlat_next;
      drv_step <= w_step_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tr_stepper.sv
`default_nettype none
// ============================================================================
// Module  : tb_tr_stepper
// Purpose : Self-checking bench for tr_stepper (vector table, random stimulus
//           against an arithmetic reference, and timing sequences).
// Rev     : 1.0  initial release
// ============================================================================
module tb_tr_stepper;

  localparam longint unsigned c_CLK_HZ = 50000000;
  localparam int              c_LSH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0;
  logic        tr_mode_enable = 1'b0;
  logic [35:0] x = '0;
  logic [31:0] x0 = 32'd5, dx1 = 32'd250, dx2 = 32'd555, k = 32'd2304;
  logic [31:0] F1 = 32'd6000, F2 = 32'd50000;
  logic        drv_step, drv_dir, drv_enable_SM;
  logic [16:0] N;

  int     n_vec = 0;
  int     n_err = 0;
  longint cyc = 0;
  longint rise_q[$];
  longint fall_q[$];
  logic   step_prev = 1'b0;

  int  exp_n;
  bit  exp_dir, exp_en;

  tr_stepper #(.CLK_HZ(50000000), .L_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .tr_mode_enable(tr_mode_enable),
    .x(x), .x0(x0), .dx1(dx1), .dx2(dx2), .k(k), .F1(F1), .F2(F2),
    .drv_step(drv_step), .drv_dir(drv_dir), .drv_enable_SM(drv_enable_SM), .N(N)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (drv_step && !step_prev) rise_q.push_back(cyc);
    if (!drv_step && step_prev) fall_q.push_back(cyc);
    step_prev = drv_step;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name);
    check({name, " N"},   longint'(N), longint'(exp_n));
    check({name, " dir"}, longint'(drv_dir), longint'(exp_dir));
    check({name, " en"},  longint'(drv_enable_SM), longint'(exp_en));
  endtask

  function automatic int exp_hi(input int n);
`ifdef TR_HALF_DUTY_EN
    return n / 2;
`else
    return 1;
`endif
  endfunction

  function automatic longint fall_after(input longint t);
    foreach (fall_q[i]) if (fall_q[i] > t) return fall_q[i];
    return -1;
  endfunction

  // Reference: straight arithmetic on the mapping rules.
  function automatic void model(input logic [35:0] xs, input logic [31:0] m_x0,
                                input logic [31:0] m_dx1, input logic [31:0] m_dx2,
                                input logic [31:0] m_k, input logic [31:0] m_f1,
                                input logic [31:0] m_f2,
                                output bit dead, output bit dir, output int q);
    longint unsigned xv, dx, f, qq;
    xv   = xs;
    dir  = (xv >= m_x0);
    dx   = dir ? xv - m_x0 : m_x0 - xv;
    dead = (dx < m_dx1);
    if (dx >= m_dx2) f = m_f2;
    else begin
      f = m_f1 + ((longint'(m_k) * (dx - m_dx1)) >> c_LSH);
      if (f > m_f2) f = m_f2;
    end
    qq = (f == 0) ? 131071 : c_CLK_HZ / f;
    if (qq > 131071) qq = 131071;
    if (qq < 2) qq = 2;
    q = int'(qq);
  endfunction

  task automatic apply_sample(input logic [35:0] xs);
    @(negedge clk);
    x = xs;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (21) @(negedge clk);
  endtask

  task automatic wait_rises(input int n, input int budget, input string name);
    int i = 0;
    while (rise_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (rise_q.size() < n) check({name, " timeout"}, rise_q.size(), n);
  endtask

  task automatic set_defaults();
    x0 = 32'd5; dx1 = 32'd250; dx2 = 32'd555; k = 32'd2304;
    F1 = 32'd6000; F2 = 32'd50000;
  endtask

  typedef struct {
    logic [35:0] xs;
    logic [31:0] x0, dx1, dx2, k, f1, f2;
    int          n;
    bit          dir, en;
  } vec_t;

  vec_t tbl[18];

  initial begin
    longint p0;
    bit     m_dead, m_dir;
    int     m_q;

    // Spec settings: x0=5 dx1=250 dx2=555 k=2304 F1=6000 F2=50000
    tbl[0]  = '{36'd30000, 5, 250, 555, 2304, 6000, 50000, 1000, 1, 1};
    tbl[1]  = '{36'd355,   5, 250, 555, 2304, 6000, 50000, 2450, 1, 1};
    tbl[2]  = '{36'd255,   5, 250, 555, 2304, 6000, 50000, 8333, 1, 1};
    tbl[3]  = '{36'd560,   5, 250, 555, 2304, 6000, 50000, 1000, 1, 1};
    tbl[4]  = '{36'd100,   5, 250, 555, 2304, 6000, 50000, 1000, 1, 0};
    tbl[5]  = '{36'd0,  1000, 250, 555, 2304, 6000, 50000, 1000, 0, 1};
    tbl[6]  = '{36'd254,   5, 250, 555, 2304, 6000, 50000, 1000, 0, 0};
    tbl[7]  = '{36'd559,   5, 250, 555, 2304, 6000, 50000, 1004, 1, 1};
    tbl[8]  = '{36'd256,   5, 250, 555, 32'hFFFF_FFFF, 6000, 50000, 1000, 1, 1};
    tbl[9]  = '{36'd605,   5, 600, 300, 2304, 6000, 40000, 1250, 1, 1};
    tbl[10] = '{36'd604,   5, 600, 300, 2304, 6000, 40000, 1250, 1, 0};
    tbl[11] = '{36'd305,   5, 250, 555, 0, 300, 1000, 131071, 1, 1};
    tbl[12] = '{36'd30000, 5, 250, 555, 2304, 6000, 50000, 1000, 1, 1};
    tbl[13] = '{36'd305,   5, 250, 555, 0, 100, 200, 131071, 1, 1};
    tbl[14] = '{36'd560,   5, 250, 555, 2304, 6000, 50000, 1000, 1, 1};
    tbl[15] = '{36'd30000, 5, 250, 555, 2304, 0, 0, 131071, 1, 1};
    tbl[16] = '{36'd30000, 5, 250, 555, 2304, 40000000, 40000000, 2, 1, 1};
    tbl[17] = '{36'hF_FFFF_FFFF, 5, 250, 555, 2304, 6000, 25000, 2000, 1, 1};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("reset outputs", {drv_step, drv_dir, drv_enable_SM, N}, 0);
    rst = 1'b1;
    tr_mode_enable = 1'b1;
    set_defaults();

    // ---------------- latency and first pulse ----------------
    @(negedge clk);
    rise_q.delete(); fall_q.delete();
    x = 36'd30000; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("latency en before T+20", drv_enable_SM, 0);
    @(negedge clk);
    check("latency en at T+20", drv_enable_SM, 1);
    check("latency N at T+20", N, 1000);
    check("latency dir at T+20", drv_dir, 1);
    check("step low on enable cycle", drv_step, 0);
    @(negedge clk);
    check("first step pulse", drv_step, 1);
    wait_rises(3, 3000, "period 1000");
    check("period 1000 #1", rise_q[1] - rise_q[0], 1000);
    check("period 1000 #2", rise_q[2] - rise_q[1], 1000);
    check("step high width N=1000", fall_after(rise_q[0]) - rise_q[0], exp_hi(1000));

    // ---------------- N change mid-period ----------------
    rise_q.delete(); fall_q.delete();
    wait_rises(1, 1500, "sync pulse");
    p0 = rise_q[0];
    repeat (100) @(negedge clk);
    x = 36'd355; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    wait_rises(3, 5000, "N change");
    check("N change current period", rise_q[1] - p0, 1000);
    check("N change next period", rise_q[2] - rise_q[1], 2450);
    check("step high width N=2450", fall_after(rise_q[1]) - rise_q[1], exp_hi(2450));
    check("N after change", N, 2450);

    // ---------------- strobe during calculation is dropped ----------------
    @(negedge clk);
    x = 36'd560; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    x = 36'd255; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (40) @(negedge clk);
    check("dropped strobe N", N, 1000);

    // ---------------- tr_mode_enable low mid-DIV ----------------
    @(negedge clk);
    x = 36'd355; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (8) @(negedge clk);
    tr_mode_enable = 1'b0;
    @(negedge clk);
    check("abort en next edge", drv_enable_SM, 0);
    check("abort step next edge", drv_step, 0);
    rise_q.delete();
    repeat (25) @(negedge clk);
    check("abort N holds", N, 1000);
    check("abort no pulses", rise_q.size(), 0);
    tr_mode_enable = 1'b1;
    repeat (25) @(negedge clk);
    check("re-permit without sample en", drv_enable_SM, 0);
    check("re-permit without sample N", N, 1000);

    // ---------------- deadband after active ----------------
    apply_sample(36'd30000);
    check("reactivate en", drv_enable_SM, 1);
    apply_sample(36'd100);
    check("deadband en", drv_enable_SM, 0);
    check("deadband N holds", N, 1000);
    rise_q.delete();
    repeat (50) @(negedge clk);
    check("deadband no pulses", rise_q.size() + int'(drv_step), 0);

    // ---------------- asynchronous reset while active ----------------
    apply_sample(36'd30000);
    repeat (37) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("async reset outputs", {drv_step, drv_dir, drv_enable_SM, N}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post reset idle", {drv_step, drv_dir, drv_enable_SM, N}, 0);
    apply_sample(36'd560);
    check("post reset operation N", N, 1000);

    // ---------------- table-driven vectors ----------------
    foreach (tbl[i]) begin
      x0 = tbl[i].x0; dx1 = tbl[i].dx1; dx2 = tbl[i].dx2; k = tbl[i].k;
      F1 = tbl[i].f1; F2 = tbl[i].f2;
      exp_n = tbl[i].n; exp_dir = tbl[i].dir; exp_en = tbl[i].en;
      apply_sample(tbl[i].xs);
      check_outs($sformatf("vec%0d", i));
    end

    // ---------------- randomized against reference ----------------
    exp_n = 2000; exp_dir = 1'b1; exp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [35:0] xs;
      int unsigned off;
      x0  = $urandom_range(0, 200000);
      dx1 = $urandom_range(0, 3000);
      dx2 = $urandom_range(0, 3000);
      k   = ($urandom_range(0, 3) == 0) ? $urandom() : $urandom_range(0, 65535);
      F1  = $urandom_range(0, 60000);
      F2  = ($urandom_range(0, 9) == 0) ? $urandom() : $urandom_range(0, 120000);
      off = $urandom_range(0, 4000);
      if ($urandom_range(0, 1) == 1) xs = 36'(x0) + 36'(off);
      else xs = (off > x0) ? 36'd0 : 36'(x0 - off);
      if ($urandom_range(0, 15) == 0) xs = {4'($urandom_range(0, 15)), 32'($urandom())};
      model(xs, x0, dx1, dx2, k, F1, F2, m_dead, m_dir, m_q);
      if (m_dead) exp_en = 1'b0;
      else begin
        exp_n = m_q; exp_dir = m_dir; exp_en = 1'b1;
      end
      apply_sample(xs);
      check_outs($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
